// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU front-end arbiter:
// datapath width defaults, FSM state encoding and ALU opcode values.
package alu_arb_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int OP_W_DEF   = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_CAPT = 2'd2,
      ST_RESP = 2'd3
   } arb_state_e;

   // ALU opcodes; this block forwards them untouched to the ALU.
   localparam logic [OP_W_DEF-1:0] OP_LSL   = 3'd0;
   localparam logic [OP_W_DEF-1:0] OP_LSR   = 3'd1;
   localparam logic [OP_W_DEF-1:0] OP_AND   = 3'd2;
   localparam logic [OP_W_DEF-1:0] OP_OR    = 3'd3;
   localparam logic [OP_W_DEF-1:0] OP_SUB   = 3'd4;
   localparam logic [OP_W_DEF-1:0] OP_SETEQ = 3'd5;
   localparam logic [OP_W_DEF-1:0] OP_SETLT = 3'd6;
   localparam logic [OP_W_DEF-1:0] OP_NOT   = 3'd7;

   // Requester index to one-hot vector.
   function automatic logic [1:0] idx_to_oh(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundles the requester handshakes, the shared response bus and the
// ALU operand/result port. slave = arbiter side, master = environment
// (requesters plus the ALU itself).
interface alu_arbiter_if
   import alu_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OP_W   = OP_W_DEF
);

   logic [1:0]             req_valid;
   logic [1:0]             req_ready;
   logic [1:0][OP_W-1:0]   req_op;
   logic [1:0][DATA_W-1:0] req_rs;
   logic [1:0][DATA_W-1:0] req_rt;

   logic [1:0]             rsp_valid;
   logic [1:0]             rsp_ready;
   logic [DATA_W-1:0]      rsp_data;
   logic                   rsp_eq;
   logic                   rsp_lt;

   logic [OP_W-1:0]        alu_op;
   logic [DATA_W-1:0]      alu_rs;
   logic [DATA_W-1:0]      alu_rt;
   logic [DATA_W-1:0]      alu_rd;
   logic                   alu_eq;
   logic                   alu_lt;

   modport slave (
      input  req_valid, req_op, req_rs, req_rt, rsp_ready,
      input  alu_rd, alu_eq, alu_lt,
      output req_ready, rsp_valid, rsp_data, rsp_eq, rsp_lt,
      output alu_op, alu_rs, alu_rt
   );

   modport master (
      output req_valid, req_op, req_rs, req_rt, rsp_ready,
      output alu_rd, alu_eq, alu_lt,
      input  req_ready, rsp_valid, rsp_data, rsp_eq, rsp_lt,
      input  alu_op, alu_rs, alu_rt
   );

endinterface

// File: rtl/alu_rr_arbiter.sv
// Two-way grant logic. Macro ALU_ARB_RR_EN selects round-robin on
// simultaneous requests; otherwise requester 0 has fixed priority.
// The last-grant pointer is kept in both builds (reset value 1, so
// requester 0 wins the first tie) but only steers round-robin.
module alu_rr_arbiter
   import alu_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic       last_q;
   logic       last_d;
   logic [1:0] gnt;

`ifdef ALU_ARB_RR_EN
   // Round-robin: a tie goes to the requester not served last.
   always_comb begin
      gnt = 2'b00;
      if (en_i) begin
         case (req_i)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end
`else
   logic unused_last;
   assign unused_last = last_q;

   // Fixed priority: requester 0 wins any tie.
   always_comb begin
      gnt = 2'b00;
      if (en_i) begin
         if (req_i[0]) begin
            gnt = 2'b01;
         end else if (req_i[1]) begin
            gnt = 2'b10;
         end
      end
   end
`endif

   assign gnt_o = gnt;

   // Pointer moves only when a grant is actually issued.
   always_comb begin
      last_d = last_q;
      if (|gnt) begin
         last_d = gnt[1];
      end
   end

   // Last-grant pointer register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters, one operation in
// flight at a time. Optional round-robin tie-break: ALU_ARB_RR_EN.
//
// state | meaning
// IDLE  | waiting; grants a pending request and latches its operands
// EXEC  | latched operands drive the ALU
// CAPT  | ALU result and flags registered onto the response bus
// RESP  | rsp_valid to the granted requester until it accepts
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OP_W   = OP_W_DEF
)
(
   input  logic         clk_i,
   input  logic         rst_n_i,
   alu_arbiter_if.slave bus_if
);

   arb_state_e        state_q;
   arb_state_e        state_d;
   logic [1:0]        gnt;
   logic              accept;
   logic              sel_q;
   logic              sel_d;
   logic [OP_W-1:0]   op_q;
   logic [OP_W-1:0]   op_d;
   logic [DATA_W-1:0] rs_q;
   logic [DATA_W-1:0] rs_d;
   logic [DATA_W-1:0] rt_q;
   logic [DATA_W-1:0] rt_d;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;
   logic              eq_q;
   logic              eq_d;
   logic              lt_q;
   logic              lt_d;
   logic              arb_en;

   // Reset is folded in so req_ready stays low while reset is held.
   assign arb_en = (state_q == ST_IDLE) && rst_n_i;
   assign accept = |gnt;

   alu_rr_arbiter u_arb (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (arb_en),
      .req_i   (bus_if.req_valid),
      .gnt_o   (gnt)
   );

   // State register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; only the granted requester's rsp_ready matters.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_CAPT;
         ST_CAPT: state_d = ST_RESP;
         ST_RESP: if (bus_if.rsp_ready[sel_q]) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      bus_if.req_ready = gnt;
      bus_if.rsp_valid = 2'b00;
      if (state_q == ST_RESP) begin
         bus_if.rsp_valid = idx_to_oh(sel_q);
      end
   end

   // Operand latch on grant, result capture in CAPT; everything else holds.
   always_comb begin
      sel_d  = sel_q;
      op_d   = op_q;
      rs_d   = rs_q;
      rt_d   = rt_q;
      data_d = data_q;
      eq_d   = eq_q;
      lt_d   = lt_q;
      if (accept) begin
         sel_d = gnt[1];
         op_d  = bus_if.req_op[gnt[1]];
         rs_d  = bus_if.req_rs[gnt[1]];
         rt_d  = bus_if.req_rt[gnt[1]];
      end
      if (state_q == ST_CAPT) begin
         data_d = bus_if.alu_rd;
         eq_d   = bus_if.alu_eq;
         lt_d   = bus_if.alu_lt;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sel_q  <= 1'b0;
         op_q   <= '0;
         rs_q   <= '0;
         rt_q   <= '0;
         data_q <= '0;
         eq_q   <= 1'b0;
         lt_q   <= 1'b0;
      end else begin
         sel_q  <= sel_d;
         op_q   <= op_d;
         rs_q   <= rs_d;
         rt_q   <= rt_d;
         data_q <= data_d;
         eq_q   <= eq_d;
         lt_q   <= lt_d;
      end
   end

   assign bus_if.alu_op   = op_q;
   assign bus_if.alu_rs   = rs_q;
   assign bus_if.alu_rt   = rt_q;
   assign bus_if.rsp_data = data_q;
   assign bus_if.rsp_eq   = eq_q;
   assign bus_if.rsp_lt   = lt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the ALU port, requester
// driver tasks and an arbitration/latency reference model.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int DW = 8;
   localparam int OW = 3;
`ifdef ALU_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   last_gnt = 1;

   alu_arbiter_if #(.DATA_W(DW), .OP_W(OW)) bus ();

   alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus_if  (bus)
   );

   always #5 clk = ~clk;

   // {lt, eq, rd} of an ideal ALU.
   function automatic logic [9:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      case (op)
         3'd0:    r = a << b;
         3'd1:    r = a >> b;
         3'd2:    r = a & b;
         3'd3:    r = a | b;
         3'd4:    r = a - b;
         3'd5:    r = (a == b) ? 8'd1 : 8'd0;
         3'd6:    r = (a < b) ? 8'd1 : 8'd0;
         default: r = ~a;
      endcase
      return {(a < b), (a == b), r};
   endfunction

   always_comb {bus.alu_lt, bus.alu_eq, bus.alu_rd} = alu_ref(bus.alu_op, bus.alu_rs, bus.alu_rt);

   function automatic logic [1:0] oh(input int i);
      return (i == 1) ? 2'b10 : 2'b01;
   endfunction

   function automatic int exp_grant(input logic [1:0] v, input int last);
      if (v == 2'b10) return 1;
      if (v == 2'b11) return (RR && last == 0) ? 1 : 0;
      return 0;
   endfunction

   task automatic do_txn(input int idx, input logic [2:0] op, input logic [7:0] rs, input logic [7:0] rt,
                         input int hold, input bit busy);
      logic [9:0] exp;
      int n;
      int oth;
      oth = 1 - idx;
      exp = alu_ref(op, rs, rt);
      @(posedge clk); #1;
      bus.req_op[idx] = op;
      bus.req_rs[idx] = rs;
      bus.req_rt[idx] = rt;
      bus.req_valid   = oh(idx);
      bus.rsp_ready   = oh(oth);
      n = 0;
      @(negedge clk);
      while (bus.req_ready === 2'b00 && n < 8) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.req_ready !== oh(idx)) begin
         errors++;
         $display("FAIL txn_grant req_ready=%b expected %b", bus.req_ready, oh(idx));
      end
      last_gnt = idx;
      @(posedge clk); #1;
      bus.req_valid = busy ? oh(oth) : 2'b00;
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         checks++;
         if ({bus.req_ready, bus.rsp_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL txn_inflight cycle %0d ready/valid=%b expected 0000", k, {bus.req_ready, bus.rsp_valid});
         end
         checks++;
         if ({bus.alu_op, bus.alu_rs, bus.alu_rt} !== {op, rs, rt}) begin
            errors++;
            $display("FAIL txn_alu_in got %h expected %h", {bus.alu_op, bus.alu_rs, bus.alu_rt}, {op, rs, rt});
         end
      end
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== oh(idx)) begin
         errors++;
         $display("FAIL txn_latency rsp_valid=%b expected %b", bus.rsp_valid, oh(idx));
      end
      checks++;
      if ({bus.rsp_lt, bus.rsp_eq, bus.rsp_data} !== exp) begin
         errors++;
         $display("FAIL txn_result op=%0d rs=%h rt=%h got %h expected %h", op, rs, rt,
                  {bus.rsp_lt, bus.rsp_eq, bus.rsp_data}, exp);
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         checks++;
         if ({bus.req_ready, bus.rsp_valid, bus.rsp_lt, bus.rsp_eq, bus.rsp_data} !== {2'b00, oh(idx), exp}) begin
            errors++;
            $display("FAIL txn_hold cycle %0d got %h expected %h", h,
                     {bus.req_ready, bus.rsp_valid, bus.rsp_lt, bus.rsp_eq, bus.rsp_data}, {2'b00, oh(idx), exp});
         end
      end
      bus.rsp_ready = oh(idx);
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
      checks++;
      if ({bus.rsp_valid, bus.alu_op, bus.alu_rs, bus.alu_rt} !== {2'b00, op, rs, rt}) begin
         errors++;
         $display("FAIL txn_idle got %h expected %h", {bus.rsp_valid, bus.alu_op, bus.alu_rs, bus.alu_rt},
                  {2'b00, op, rs, rt});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req_valid = 2'b11;
      bus.req_op[0] = 3'd3; bus.req_rs[0] = 8'h11; bus.req_rt[0] = 8'h22;
      bus.req_op[1] = 3'd4; bus.req_rs[1] = 8'h33; bus.req_rt[1] = 8'h44;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.rsp_valid} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_handshake got %b expected 0000", {bus.req_ready, bus.rsp_valid});
      end
      checks++;
      if ({bus.rsp_data, bus.rsp_eq, bus.rsp_lt} !== 10'd0) begin
         errors++;
         $display("FAIL reset_rsp got %h expected 0", {bus.rsp_data, bus.rsp_eq, bus.rsp_lt});
      end
      checks++;
      if ({bus.alu_op, bus.alu_rs, bus.alu_rt} !== 19'd0) begin
         errors++;
         $display("FAIL reset_alu got %h expected 0", {bus.alu_op, bus.alu_rs, bus.alu_rt});
      end
      bus.req_valid = 2'b00;
      rst_n = 1'b1;
      last_gnt = 1;
   endtask

   task automatic test_single();
      do_txn(0, 3'd0, 8'd1, 8'd3, 0, 1'b0);
   endtask

   task automatic test_arbitration();
      logic [2:0] a_op[2];
      logic [7:0] a_rs[2];
      logic [7:0] a_rt[2];
      logic [9:0] p_exp;
      logic [1:0] exp_v;
      int grants, cyc, gcyc, pidx, e;
      bit pending, busy_now, granted;
      grants = 0; cyc = 0; gcyc = 0; pidx = 0; pending = 0; p_exp = '0;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         a_op[i] = 3'($urandom_range(7)); a_rs[i] = 8'($urandom); a_rt[i] = 8'($urandom_range(9));
         bus.req_op[i] = a_op[i]; bus.req_rs[i] = a_rs[i]; bus.req_rt[i] = a_rt[i];
      end
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b11;
      while ((grants < 4 || pending) && cyc < 60) begin
         @(negedge clk);
         busy_now = pending;
         granted  = 0;
         if (pending) begin
            exp_v = (cyc - gcyc == 3) ? oh(pidx) : 2'b00;
            checks++;
            if (bus.rsp_valid !== exp_v) begin
               errors++;
               $display("FAIL arb_rsp_valid cycle %0d got %b expected %b", cyc - gcyc, bus.rsp_valid, exp_v);
            end
            if (cyc - gcyc == 3) begin
               checks++;
               if ({bus.rsp_lt, bus.rsp_eq, bus.rsp_data} !== p_exp) begin
                  errors++;
                  $display("FAIL arb_result got %h expected %h", {bus.rsp_lt, bus.rsp_eq, bus.rsp_data}, p_exp);
               end
            end
            if (cyc - gcyc >= 3) pending = 0;
         end
         e = exp_grant(2'b11, last_gnt);
         exp_v = (!busy_now && grants < 4) ? oh(e) : 2'b00;
         checks++;
         if (bus.req_ready !== exp_v) begin
            errors++;
            $display("FAIL arb_grant #%0d got %b expected %b", grants, bus.req_ready, exp_v);
         end
         if (!busy_now && grants < 4) begin
            pidx = e; gcyc = cyc; pending = 1; last_gnt = e; grants++; granted = 1;
            p_exp = alu_ref(a_op[e], a_rs[e], a_rt[e]);
         end
         @(posedge clk); #1;
         cyc++;
         if (granted) begin
            if (grants == 4) begin
               bus.req_valid = 2'b00;
            end else begin
               a_op[pidx] = 3'($urandom_range(7)); a_rs[pidx] = 8'($urandom); a_rt[pidx] = 8'($urandom_range(9));
               bus.req_op[pidx] = a_op[pidx]; bus.req_rs[pidx] = a_rs[pidx]; bus.req_rt[pidx] = a_rt[pidx];
            end
         end
      end
      checks++;
      if (cyc >= 60) begin
         errors++;
         $display("FAIL arb_timeout grants=%0d expected 4", grants);
      end
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
   endtask

   task automatic test_hold();
      do_txn(1, 3'd4, 8'd0, 8'd1, 5, 1'b1);
   endtask

   task automatic test_flags();
      do_txn(0, 3'd6, 8'd1, 8'd2, 0, 1'b0);
      checks++;
      if (bus.rsp_lt !== 1'b1) begin
         errors++;
         $display("FAIL flag_lt got %b expected 1", bus.rsp_lt);
      end
      do_txn(0, 3'd5, 8'd1, 8'd1, 1, 1'b0);
      checks++;
      if (bus.rsp_eq !== 1'b1) begin
         errors++;
         $display("FAIL flag_eq got %b expected 1", bus.rsp_eq);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         do_txn(int'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom), 8'($urandom_range(10)),
                int'($urandom_range(3)), 1'($urandom_range(1)));
      end
   endtask

   task automatic test_mid_reset();
      int e;
      do_txn(1, 3'd7, 8'h00, 8'h00, 0, 1'b0);
      @(posedge clk); #1;
      bus.req_op[0] = 3'd7; bus.req_rs[0] = 8'hA5; bus.req_rt[0] = 8'h3C;
      bus.req_valid = 2'b01;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b01) begin
         errors++;
         $display("FAIL abort_grant got %b expected 01", bus.req_ready);
      end
      last_gnt = 0;
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_eq, bus.rsp_lt,
           bus.alu_op, bus.alu_rs, bus.alu_rt} !== 33'd0) begin
         errors++;
         $display("FAIL abort_async got %h expected 0", {bus.req_ready, bus.rsp_valid, bus.rsp_data,
                  bus.rsp_eq, bus.rsp_lt, bus.alu_op, bus.alu_rs, bus.alu_rt});
      end
      last_gnt = 1;
      @(negedge clk);
      rst_n = 1'b1;
      bus.rsp_ready = 2'b11;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (bus.rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL abort_no_rsp cycle %0d got %b expected 00", i, bus.rsp_valid);
         end
      end
      @(posedge clk); #1;
      bus.req_valid = 2'b11;
      e = exp_grant(2'b11, last_gnt);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== oh(e)) begin
         errors++;
         $display("FAIL post_reset_grant got %b expected %b", bus.req_ready, oh(e));
      end
      last_gnt = e;
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      repeat (5) @(posedge clk);
      #1;
      bus.rsp_ready = 2'b00;
   endtask

   initial begin
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
      bus.req_op    = '0;
      bus.req_rs    = '0;
      bus.req_rt    = '0;
      test_reset();
      test_arbitration();
      test_single();
      test_hold();
      test_flags();
      test_random();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, 8, operand/result width; SHALL match the ALU datapath width.
REQ-002 Parameter OP_W, 3, ALU opcode width.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  2  per-requester operation request (index 0, 1).
REQ-006 req_ready  output  2  one-hot grant pulse; request accepted when valid&&ready.
REQ-007 req_op  input  2xOP_W  per-requester ALU opcode.
REQ-008 req_rs, req_rt  input  2xDATA_W each  per-requester operands.
REQ-009 rsp_valid  output  2  per-requester result valid, at most one bit set.
REQ-010 rsp_ready  input  2  per-requester result accept.
REQ-011 rsp_data  output  DATA_W  shared result bus; rsp_eq, rsp_lt  output  1 each  captured ALU flags.
REQ-012 alu_op, alu_rs, alu_rt  output  OP_W/DATA_W/DATA_W  drive ALU ALUop/srcRS/srcRT.
REQ-013 alu_rd, alu_eq, alu_lt  input  DATA_W/1/1  from ALU destRD/equalFlag/lessThanFlag.

Function
REQ-014 FSM states IDLE, EXEC, CAPT, RESP; exactly one request in flight at any time.
REQ-015 IDLE: if any req_valid, grant one requester, assert its req_ready for exactly one cycle, latch its op/rs/rt, go EXEC; else stay IDLE with req_ready=0.
REQ-016 req_ready SHALL be 0 in EXEC, CAPT, RESP; new requests wait, never dropped.
REQ-017 EXEC: alu_op/rs/rt driven from latched values (held stable through CAPT); go CAPT.
REQ-018 CAPT: register alu_rd, alu_eq, alu_lt into rsp_data/rsp_eq/rsp_lt; go RESP.
REQ-019 RESP: assert rsp_valid of granted requester only; hold rsp_data/rsp_eq/rsp_lt stable until rsp_ready of that requester; then IDLE.
REQ-020 Latency: accept at edge N -> rsp_valid high from cycle N+3; minimum issue interval 4 cycles.
REQ-021 rsp_ready of the non-granted requester SHALL be ignored.
REQ-022 Opcodes passed unchanged (0 lsl,1 lsr,2 and,3 or,4 sub,5 seteq,6 setlt,7 not); no arithmetic in this block.
REQ-023 In IDLE, alu_op/rs/rt SHALL hold last issued values (no spurious op changes).
REQ-024 Grant with both req_valid set: policy per REQ-027/028; grant pointer updates only on accept.

Reset
REQ-025 RESET_N low: state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_eq=0, rsp_lt=0, alu_op/rs/rt=0, last-grant pointer=1.
REQ-026 Reset mid-operation abandons the in-flight request; no rsp_valid is issued for it after release.

Configuration
REQ-027 With ALU_ARB_RR_EN defined: round-robin; on simultaneous requests grant the requester not granted last (requester 0 first after reset).
REQ-028 Without ALU_ARB_RR_EN: fixed priority, requester 0 always wins simultaneous requests; pointer unused.

Structure
REQ-029 Package alu_arb_pkg SHALL hold the FSM state enum, ALU opcode constants, and DATA_W/OP_W defaults.
REQ-030 Grant logic SHALL be the sub-module alu_rr_arbiter (2 requests, one-hot grant, pointer, macro-dependent policy).

Verification
REQ-031 Single req0 op=0 rs=1 rt=3 -> req_ready[0] one cycle, rsp_valid[0] 3 cycles later, rsp_data=8.
REQ-032 req0 and req1 both valid continuously with RR_EN -> grants alternate 0,1,0,1; without -> four grants all to 0.
REQ-033 req1 op=4 rs=0 rt=1, rsp_ready[1] held low 5 cycles -> rsp_data=0xFF stable, rsp_valid[1] high throughout, no new grant.
REQ-034 req0 op=6 rs=1 rt=2 -> rsp_lt=1; then op=5 rs=1 rt=1 -> rsp_eq=1.
REQ-035 RESET_N low during CAPT -> all outputs at reset values asynchronously; after release no rsp_valid for the aborted request.
